// File: rtl/serialiser.sv
// rtl/serialiser.sv - byte-to-bit transmit serialiser, LSB first, ISO 14443-3A odd parity per full byte.
// Optional CRC_A append when SERIALISER_CRC_EN is defined.
module serialiser (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [2:0] in_bits,
    input  logic       in_last,
`ifdef SERIALISER_CRC_EN
    input  logic       append_crc,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic       out_last
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_WAIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [2:0] bits_q, bits_d;
    logic       last_q, last_d;
    logic [2:0] cnt_q, cnt_d;
    logic       par_q, par_d;

    logic       full;
    logic       final_bit;
    logic       consume;
    logic       cur_bit;
    logic       byte_done;
    logic       load;
    logic       crc_next;

`ifdef SERIALISER_CRC_EN
    logic        crc_en_q, crc_en_d;
    logic [15:0] crc_q, crc_d;
    logic [1:0]  stage_q, stage_d;

    // CRC bytes follow the last full data byte and the CRC low byte.
    assign crc_next = crc_en_q & last_q & full & (stage_q != 2'd2);
`else
    assign crc_next = 1'b0;
`endif

    // A partial count on a non-final byte is treated as a full byte.
    assign full      = (bits_q == 3'd0) | ~last_q;
    assign final_bit = full ? (cnt_q == 3'd7) : (cnt_q == (bits_q - 3'd1));
    assign consume   = out_valid & out_ready;
    assign cur_bit   = byte_q[cnt_q];

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bits_d    = bits_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        out_valid = 1'b0;
        out_data  = 1'b0;
        out_last  = 1'b0;
        in_ready  = 1'b0;
        byte_done = 1'b0;
        load      = 1'b0;
`ifdef SERIALISER_CRC_EN
        crc_en_d  = crc_en_q;
        crc_d     = crc_q;
        stage_d   = stage_q;
`endif

        case (state_q)
            S_IDLE, S_WAIT: begin
                in_ready = 1'b1;
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_data  = cur_bit;
                out_last  = ~full & final_bit;
                if (consume) begin
                    par_d = par_q ^ cur_bit;
                    cnt_d = cnt_q + 3'd1;
`ifdef SERIALISER_CRC_EN
                    if (crc_en_q && stage_q == 2'd0) begin
                        crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ cur_bit) ? 16'h8408 : 16'h0000);
                    end
`endif
                    if (final_bit) begin
                        if (full) begin
                            state_d = S_PARITY;
                        end else begin
                            byte_done = 1'b1;
                        end
                    end
                end
            end
            S_PARITY: begin
                out_valid = 1'b1;
                out_data  = par_q;
                out_last  = last_q & ~crc_next;
                if (consume) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (byte_done) begin
            if (last_q) begin
                state_d = S_IDLE;
`ifdef SERIALISER_CRC_EN
                if (crc_next) begin
                    state_d = S_DATA;
                    byte_d  = (stage_q == 2'd0) ? crc_q[7:0] : crc_q[15:8];
                    bits_d  = 3'd0;
                    cnt_d   = 3'd0;
                    par_d   = 1'b1;
                    stage_d = stage_q + 2'd1;
                end
`endif
            end else begin
                in_ready = 1'b1;
                state_d  = S_WAIT;
            end
        end

        in_ready = in_ready & ~rst;
        load     = in_valid & in_ready;

        if (load) begin
            state_d = S_DATA;
            byte_d  = in_data;
            bits_d  = in_bits;
            last_d  = in_last;
            cnt_d   = 3'd0;
            par_d   = 1'b1;
`ifdef SERIALISER_CRC_EN
            // The CRC flag and seed belong to the frame, so only its first byte sets them.
            if (state_q == S_IDLE) begin
                crc_en_d = append_crc;
                crc_d    = 16'h6363;
                stage_d  = 2'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            byte_q  <= 8'd0;
            bits_q  <= 3'd0;
            last_q  <= 1'b0;
            cnt_q   <= 3'd0;
            par_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            bits_q  <= bits_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

`ifdef SERIALISER_CRC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_en_q <= 1'b0;
            crc_q    <= 16'h6363;
            stage_q  <= 2'd0;
        end else begin
            crc_en_q <= crc_en_d;
            crc_q    <= crc_d;
            stage_q  <= stage_d;
        end
    end
`endif

endmodule

// File: tb/tb_serialiser.sv
// tb/tb_serialiser.sv - scoreboard bench for serialiser; CRC cases built when SERIALISER_CRC_EN is defined.
module tb_serialiser;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_bits;
    logic       in_last;
    logic       append_crc;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_data;
    logic       out_last;

    always #5 clk = ~clk;

    serialiser dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bits   (in_bits),
        .in_last   (in_last),
`ifdef SERIALISER_CRC_EN
        .append_crc(append_crc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    logic [1:0] exp_q[$];
    logic [1:0] exp_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    bit  throttle = 1'b0;
    bit  rdy_level = 1'b1;
    bit  mark = 1'b0;
    int  mark_cyc = 0;
    int  last_pop_cyc = 0;
    bit  stall_seen = 1'b0;
    logic stall_d, stall_l;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = throttle ? ($urandom_range(3) != 0) : rdy_level;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected {data,last} on every consumed bit.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_seen && out_valid) begin
                check("hold_data", out_data, stall_d);
                check("hold_last", out_last, stall_l);
            end
            stall_seen = out_valid && !out_ready;
            stall_d    = out_data;
            stall_l    = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bit: got data=%0b last=%0b expected no bit", out_data, out_last);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("bit", {out_data, out_last}, exp_e);
                end
                if (out_last) check("in_ready_at_frame_end", in_ready, 1'b0);
                if (mark) begin
                    mark_cyc = cyc;
                    mark     = 1'b0;
                end
                last_pop_cyc = cyc;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic [2:0] b, input logic last, input logic more);
        int n;
        n = (b == 3'd0) ? 8 : int'(b);
        for (int i = 0; i < n; i++)
            exp_q.push_back({d[i], (b != 3'd0) && last && (i == n - 1)});
        if (b == 3'd0) exp_q.push_back({~^d, last && !more});
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] b, input logic last, input logic more);
        int t;
        bit acc;
        push_byte(d, b, last, more);
        in_data  = d;
        in_bits  = b;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 2000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept of %0h", d);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d bits pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int nbits, nb, rem;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_bits = 3'd0;
        in_last = 1'b0;
        append_crc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 1'b0);
        check("reset_out_last", out_last, 1'b0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        // 0x44 full last byte: 0,0,1,0,0,0,1,0 then parity 1
        send(8'h44, 3'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();
        check("idle_in_ready", in_ready, 1'b1);

        // 0x26 partial, 7 bits, no parity
        send(8'h26, 3'd7, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

        // back-to-back 0x00,0xFF,0x01: 27 contiguous bits
        mark = 1'b1;
        send(8'h00, 3'd0, 1'b0, 1'b0);
        send(8'hFF, 3'd0, 1'b0, 1'b0);
        send(8'h01, 3'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();
        check("no_bubble_span", last_pop_cyc - mark_cyc, 26);

        // mid-frame underflow
        send(8'h5A, 3'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #1;
        repeat (5) begin
            @(negedge clk);
            check("gap_out_valid", out_valid, 1'b0);
            check("gap_in_ready", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        send(8'hC3, 3'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

        // reset mid-byte
        send(8'hA5, 3'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 6 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        rdy_level = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("rst_mid_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        rdy_level = 1'b1;
        send(8'h3C, 3'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

`ifdef SERIALISER_CRC_EN
        append_crc = 1'b1;
        send(8'h00, 3'd0, 1'b0, 1'b0);
        append_crc = 1'b0;
        send(8'h00, 3'd0, 1'b1, 1'b1);
        in_valid = 1'b0;
        push_byte(8'hA0, 3'd0, 1'b1, 1'b1);
        push_byte(8'h1E, 3'd0, 1'b1, 1'b0);
        drain();
        append_crc = 1'b1;
        send(8'h12, 3'd0, 1'b0, 1'b0);
        append_crc = 1'b0;
        send(8'h34, 3'd0, 1'b1, 1'b1);
        in_valid = 1'b0;
        push_byte(8'h26, 3'd0, 1'b1, 1'b1);
        push_byte(8'hCF, 3'd0, 1'b1, 1'b0);
        drain();
`endif

        // random frames with throttled out_ready
        throttle = 1'b1;
        for (int f = 0; f < 600; f++) begin
            nbits = $urandom_range(80, 1);
            nb    = (nbits + 7) / 8;
            rem   = nbits % 8;
            for (int k = 0; k < nb; k++) begin
                if (k == nb - 1)
                    send(8'($urandom), (rem != 0) ? 3'(rem) : 3'd0, 1'b1, 1'b0);
                else
                    send(8'($urandom), 3'd0, 1'b0, 1'b0);
            end
            in_valid = 1'b0;
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end
        drain();
        throttle = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
